// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DM_ACC = 2'd1,
        IM_ACC = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arb_wdog.sv
// Wait-cycle watchdog: saturating per-access counter and sticky timeout flag.
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic acc,
    input  logic mem_ready,
    output logic expire,
    output logic err
);

    localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Clearing on every completion gives the DM->IM hand-off a fresh count.
    always_comb begin
        expire = acc && !mem_ready && (cnt_q == CNT_LAST);
        cnt_d  = cnt_q;
        if (!acc || mem_ready || expire) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        err_d = err_q | expire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU data and instruction ports onto one single-port memory,
// data side first, with a watchdog that abandons stuck accesses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] IM_address,
    input  logic              IM_enable,
    output logic [DATA_W-1:0] IM_out,
    input  logic [ADDR_W-1:0] DM_address,
    input  logic [DATA_W-1:0] DM_in,
    input  logic              DM_enable,
    input  logic              DM_write,
    output logic [DATA_W-1:0] DM_out,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
    logic              dm_write_q, dm_write_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic              im_en_q, im_en_d;
    logic [DATA_W-1:0] im_out_q, im_out_d;
    logic [DATA_W-1:0] dm_out_q, dm_out_d;

    logic acc;
    logic wdog_expire;
    logic acc_done;

    assign acc      = (state_q == DM_ACC) || (state_q == IM_ACC);
    assign acc_done = mem_ready || wdog_expire;

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .acc       (acc),
        .mem_ready (mem_ready),
        .expire    (wdog_expire),
        .err       (err)
    );

    always_comb begin
        state_d    = state_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_write_d = dm_write_q;
        im_addr_d  = im_addr_q;
        im_en_d    = im_en_q;
        im_out_d   = im_out_q;
        dm_out_d   = dm_out_q;

        case (state_q)
            IDLE: begin
                if (DM_enable || IM_enable) begin
                    dm_addr_d  = DM_address;
                    dm_wdata_d = DM_in;
                    dm_write_d = DM_write;
                    im_addr_d  = IM_address;
                    im_en_d    = IM_enable;
                    state_d    = DM_enable ? DM_ACC : IM_ACC;
                end
            end
            DM_ACC: begin
                // A timed-out access never captures, so the output holds.
                if (mem_ready && !dm_write_q) begin
                    dm_out_d = mem_rdata;
                end
                if (acc_done) begin
                    state_d = im_en_q ? IM_ACC : DONE;
                end
            end
            IM_ACC: begin
                if (mem_ready) begin
                    im_out_d = mem_rdata;
                end
                if (acc_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            dm_write_q <= 1'b0;
            im_addr_q  <= '0;
            im_en_q    <= 1'b0;
            im_out_q   <= '0;
            dm_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_write_q <= dm_write_d;
            im_addr_q  <= im_addr_d;
            im_en_q    <= im_en_d;
            im_out_q   <= im_out_d;
            dm_out_q   <= dm_out_d;
        end
    end

    assign mem_req   = acc;
    assign mem_we    = (state_q == DM_ACC) && dm_write_q;
    assign mem_addr  = (state_q == IM_ACC) ? im_addr_q : dm_addr_q;
    assign mem_wdata = dm_wdata_q;
    assign stall     = acc || ((state_q == IDLE) && (IM_enable || DM_enable));
    assign IM_out    = im_out_q;
    assign DM_out    = dm_out_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_W, 32, address width.
  DATA_W, 32, data width.
  TIMEOUT, 255, max wait cycles for mem_ready before the error flag sets.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; one clock, all flops on its rising edge.
  rst  in  1  asynchronous, active-high reset.
  IM_address  in  ADDR_W  CPU fetch address.
  IM_enable  in  1  fetch request.
  IM_out  out  DATA_W  fetched instruction, registered.
  DM_address  in  ADDR_W  CPU load/store address.
  DM_in  in  DATA_W  store data.
  DM_enable  in  1  data request.
  DM_write  in  1  1 = store, 0 = load.
  DM_out  out  DATA_W  load data, registered.
  stall  out  1  freezes the CPU pipeline.
  mem_req  out  1  request to the single-port memory.
  mem_addr  out  ADDR_W  memory address.
  mem_we  out  1  memory write strobe.
  mem_wdata  out  DATA_W  memory write data.
  mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
  mem_ready  in  1  memory completion, one-cycle pulse.
  err  out  1  sticky timeout flag.

Function
REQ-003 The FSM SHALL have four states: IDLE, DM_ACC, IM_ACC, DONE.
REQ-004 In IDLE, DM_enable=1 SHALL transition to DM_ACC; else IM_enable=1 SHALL transition to IM_ACC; else the FSM SHALL stay in IDLE. DM has fixed priority.
REQ-005 On leaving IDLE, the block SHALL latch DM_address, DM_in, DM_write, IM_address and IM_enable into internal registers. mem_addr, mem_we and mem_wdata SHALL be driven only from these latched copies.
REQ-006 In DM_ACC and IM_ACC, mem_req SHALL be 1 every cycle until and including the mem_ready cycle. mem_we SHALL be 1 only in DM_ACC with latched DM_write=1.
REQ-007 On mem_ready in DM_ACC:
  - On a load, DM_out SHALL capture mem_rdata; on a store, DM_out SHALL hold.
  - Next state SHALL be IM_ACC if latched IM_enable=1, else DONE.
REQ-008 On mem_ready in IM_ACC, IM_out SHALL capture mem_rdata and the next state SHALL be DONE.
REQ-009 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-010 stall SHALL be combinational:
  - 1 in DM_ACC and IM_ACC.
  - 1 in IDLE when IM_enable|DM_enable.
  - 0 in DONE and in idle-without-request.
REQ-011 IM_out and DM_out SHALL be stable throughout DONE and SHALL hold their values until the next capture.
REQ-012 Minimum latency: fetch-only request = 3 cycles (IDLE, IM_ACC with ready, DONE); DM+IM request = 4 cycles.
REQ-013 mem_ready SHALL be ignored outside DM_ACC and IM_ACC.
REQ-014 A wait counter SHALL reset on entry to each ACC state and increment every cycle without mem_ready. When it reaches TIMEOUT:
  - err SHALL set and stay set until reset.
  - The current access SHALL be abandoned with its data output unchanged.
  - The FSM SHALL proceed as if mem_ready had arrived.
REQ-015 The counter width SHALL be $clog2(TIMEOUT+1) and the counter SHALL saturate, never wrap.
REQ-016 Requests that change while stall=1 SHALL be ignored; only the latched copies are used.

Reset
REQ-017 rst=1 SHALL asynchronously force:
  - state = IDLE;
  - IM_out, DM_out, err, wait counter and latched registers = 0;
  - mem_req = 0 and mem_we = 0 immediately, including mid-access.
REQ-018 After rst deasserts, the first request SHALL be evaluated in the first rising clk edge's IDLE cycle.

Structure
REQ-019 The state enum and default TIMEOUT SHALL live in the shared package mem_arb_pkg.
REQ-020 One sub-module, mem_arb_wdog, SHALL hold the wait counter and the sticky err. The FSM, latches and muxing SHALL stay in mem_arbiter.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - Fetch-only: IM_enable=1, IM_address=0x1000_0000, mem_ready one cycle after mem_req, mem_rdata=0x0000_0013 -> IM_out=0x13 in DONE; stall=1 for 2 cycles, then 0.
  - Load plus fetch: DM_enable=1, DM_write=0, DM_address=0x20, rdata 0xDEAD_BEEF, then fetch rdata 0x0050_0093 -> DM access issued first; DM_out=0xDEADBEEF, IM_out=0x00500093; stall high 3 cycles.
  - Store: DM_write=1, DM_in=0xCAFE_F00D -> mem_we=1 only in DM_ACC, mem_wdata=0xCAFEF00D, DM_out unchanged.
  - Timeout with TIMEOUT=4: mem_ready never asserted -> err=1 after 4 wait cycles, FSM reaches DONE, err stays 1.
  - Mid-access reset: rst pulsed during IM_ACC -> mem_req=0 in the same cycle, state IDLE, outputs 0.
  - Address change under stall: IM_address changed during DM_ACC -> mem_addr in IM_ACC equals the originally latched address.
